// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the ROM arbiter and its ROM instance.
package rom_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int unsigned ROM_DW   = 32;
  // Requester index width sized for the largest supported NREQ (8).
  localparam int unsigned MAX_IDXW = 3;

  // Tag travelling alongside each ROM read until its data is returned.
  typedef struct packed {
    logic                vld;
    logic [MAX_IDXW-1:0] idx;
    logic                last;
  } beat_tag_t;

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from last_grant+1.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = IW'((32'(last_grant) + off) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin burst arbiter sharing one 1-cycle synchronous ROM among NREQ requesters.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned LENWIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ*LENWIDTH-1:0]  req_len,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [ROM_DW-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic [ADDRWIDTH-1:0]      rom_rd_addr,
  input  logic [ROM_DW-1:0]         rom_rd_data,
  output logic                      busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t               state, state_next;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        gnt_reg;
  logic [ADDRWIDTH-1:0] addr_reg;
  logic [LENWIDTH-1:0]  cnt;
  beat_tag_t            p0, p1, p0_next;

  logic [NREQ-1:0]      pick_oh;
  logic [IW-1:0]        pick_idx;
  logic [ADDRWIDTH-1:0] sel_addr;
  logic [LENWIDTH-1:0]  sel_len;
  logic [NREQ-1:0]      rsp_oh;
  logic                 accept;
  logic                 issue;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (pick_oh),
    .gnt_idx    (pick_idx)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr = req_addr[i*ADDRWIDTH +: ADDRWIDTH];
        sel_len  = req_len[i*LENWIDTH +: LENWIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    issue      = 1'b0;
    p0_next    = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = pick_oh;
          accept     = 1'b1;
          state_next = BURST;
        end
      end
      BURST: begin
        issue        = 1'b1;
        p0_next.vld  = 1'b1;
        p0_next.idx  = MAX_IDXW'(gnt_reg);
        p0_next.last = (cnt == '0);
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_oh = NREQ'(1) << p1.idx;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      last_grant  <= IW'(NREQ - 1);
      gnt_reg     <= '0;
      addr_reg    <= '0;
      cnt         <= '0;
      rom_rd_addr <= '0;
      p0          <= '0;
      p1          <= '0;
      rsp_valid   <= '0;
      rsp_last    <= 1'b0;
      rsp_data    <= '0;
      busy        <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_reg   <= sel_addr;
        cnt        <= sel_len;
        gnt_reg    <= pick_idx;
        last_grant <= pick_idx;
      end else if (issue) begin
        addr_reg <= addr_reg + 1'b1;
        cnt      <= cnt - 1'b1;
      end
      if (issue) rom_rd_addr <= addr_reg;
      // p0 marks the cycle the ROM sees the address, p1 the cycle its data is valid.
      p0        <= p0_next;
      p1        <= p0;
      rsp_valid <= p1.vld ? rsp_oh : '0;
      rsp_last  <= p1.vld & p1.last;
      if (p1.vld) rsp_data <= rom_rd_data;
      busy <= (state_next == BURST) | p0_next.vld | p0.vld;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a behavioural 1-cycle ROM.
module tb_rom_arbiter;

  logic        clk;
  logic        reset_l;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic [7:0]  rom_rd_addr;
  logic [31:0] rom_rd_data;
  logic        busy;

  int checks;
  int errors;

  rom_arbiter #(.ADDRWIDTH(8), .NREQ(4), .LENWIDTH(4)) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rom_rd_addr (rom_rd_addr),
    .rom_rd_data (rom_rd_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: mem[k] = k * 0x01010101, registered read, no reset.
  always @(posedge clk) rom_rd_data <= {4{rom_rd_addr}};

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {4{a}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l   = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
  endtask

  // One burst of n words from requester r at base; optionally disturb operands mid-burst.
  task automatic do_burst(input int r, input logic [7:0] base, input int n, input bit perturb);
    logic [3:0] oh;
    oh = 4'(1) << r;
    req_addr[r*8 +: 8] = base;
    req_len[r*4 +: 4]  = 4'(n - 1);
    req_valid          = oh;
    #1 chk("accept_ready", 32'(req_ready), 32'(oh));
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("ready_in_burst", 32'(req_ready), 32'h0);
        req_valid = '0;
      end
      if (c == 2) chk("busy_burst", 32'(busy), 32'h1);
      if (perturb && c == 2) begin
        req_addr[r*8 +: 8] = ~base;
        req_len[r*4 +: 4]  = 4'h0;
      end
      if (c >= 2 && c <= n + 1) chk("rom_addr", 32'(rom_rd_addr), 32'(8'(base + 8'(c - 2))));
      if (c >= 4 && c <= n + 3) begin
        chk("beat_valid", 32'(rsp_valid), 32'(oh));
        chk("beat_data", rsp_data, rom_word(8'(base + 8'(c - 4))));
        chk("beat_last", 32'(rsp_last), 32'(c == n + 3));
      end else begin
        chk("no_beat", 32'(rsp_valid), 32'h0);
      end
    end
    chk("busy_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] exp_oh;
    int         k;
    checks    = 0;
    errors    = 0;
    reset_l   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_last", 32'(rsp_last), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rom_addr", 32'(rom_rd_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_l = 1'b1;
    @(negedge clk);

    // Single request, then address wrap-around.
    do_burst(0, 8'h10, 4, 1'b0);
    @(negedge clk);
    do_burst(1, 8'hFE, 4, 1'b0);

    // Contention after reset: all four requesters, single-word bursts.
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i*8 +: 8] = 8'h20 + 8'(i);
    req_len   = '0;
    req_valid = 4'hF;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    #1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 9) req_valid = '0;
      #1;
      exp_oh = (c % 2 == 0 && c <= 8) ? seq[c/2] : 4'h0;
      chk("rr_ready", 32'(req_ready), 32'(exp_oh));
      if (c >= 4 && c % 2 == 0 && c <= 12) begin
        k = (c - 4) / 2;
        chk("rr_rsp_valid", 32'(rsp_valid), 32'(seq[k]));
        chk("rr_rsp_last", 32'(rsp_last), 32'h1);
        chk("rr_rsp_data", rsp_data, rom_word(8'h20 + 8'($clog2(seq[k]))));
      end else begin
        chk("rr_no_rsp", 32'(rsp_valid), 32'h0);
      end
    end

    // Fairness after reset with only requesters 2 and 3 active.
    do_reset();
    req_valid = 4'b1100;
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0100;
    #1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) req_valid = '0;
      #1;
      exp_oh = (c % 2 == 0 && c <= 4) ? seq[c/2] : 4'h0;
      chk("fair_ready", 32'(req_ready), 32'(exp_oh));
      if (c >= 4 && c % 2 == 0) chk("fair_rsp", 32'(rsp_valid), 32'(seq[(c-4)/2]));
    end

    // Reset asserted after the fifth beat of a 16-word burst.
    do_reset();
    req_addr[7:0] = 8'h40;
    req_len[3:0]  = 4'hF;
    req_valid     = 4'b0001;
    #1 chk("mid_ready", 32'(req_ready), 32'h1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = '0;
      if (c >= 4) begin
        chk("mid_beat_valid", 32'(rsp_valid), 32'h1);
        chk("mid_beat_data", rsp_data, rom_word(8'h40 + 8'(c - 4)));
      end
    end
    reset_l = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_rsp_last", 32'(rsp_last), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_rom_addr", 32'(rom_rd_addr), 32'h0);
    @(negedge clk);
    reset_l = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale_beat", 32'(rsp_valid), 32'h0);
      chk("no_stale_busy", 32'(busy), 32'h0);
    end
    do_burst(1, 8'h80, 2, 1'b0);

    // Operand changes mid-burst must not affect the latched burst.
    @(negedge clk);
    do_burst(0, 8'h30, 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
